// File: rtl/ram_port_b_arbiter.sv
// ram_port_b_arbiter: shares RAM port B between the load/store bridge (M0)
// and the DMA engine (M1) over AXI4-Lite. Read and write channels each have
// their own IDLE/ADDR/RESP FSM and hold a grant for a whole transaction.
// Optional macro RAM_ARB_FIXED_PRIO_EN: M0 wins every tie (no round-robin).
// The owner register doubles as the round-robin "last granted" pointer.
// Its reset value is M1, so M0 wins the first tie after reset.
module ram_port_b_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    // master 0
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_awvalid,
    input  logic                m0_wvalid,
    input  logic                m0_bready,
    input  logic                m0_arvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    output logic                m0_awready,
    output logic                m0_wready,
    output logic                m0_bvalid,
    output logic                m0_arready,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    // master 1
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_awvalid,
    input  logic                m1_wvalid,
    input  logic                m1_bready,
    input  logic                m1_arvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    output logic                m1_awready,
    output logic                m1_wready,
    output logic                m1_bvalid,
    output logic                m1_arready,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    // RAM port B
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_awvalid,
    output logic                s_wvalid,
    output logic                s_bready,
    output logic                s_arvalid,
    output logic                s_rready,
    input  logic                s_awready,
    input  logic                s_wready,
    input  logic                s_bvalid,
    input  logic                s_arready,
    input  logic                s_rvalid,
    input  logic [DATA_W-1:0]   s_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, RESP = 2'd2} state_t;

    state_t r_state_q, r_state_d;
    state_t w_state_q, w_state_d;
    logic   r_owner_q, r_owner_d;   // 0 = M0, 1 = M1; also "last granted"
    logic   w_owner_q, w_owner_d;

    logic   w_req0, w_req1;
    logic   r_pick, w_pick;
    logic   w_addr_hs;
    logic   r_own_rready, w_own_bready;

    // A write request needs AW and W together.
    assign w_req0 = m0_awvalid && m0_wvalid;
    assign w_req1 = m1_awvalid && m1_wvalid;

    // Winner when at least one master requests; only sampled in IDLE.
`ifdef RAM_ARB_FIXED_PRIO_EN
    assign r_pick = !m0_arvalid;
    assign w_pick = !w_req0;
`else
    assign r_pick = (m0_arvalid && m1_arvalid) ? !r_owner_q : m1_arvalid;
    assign w_pick = (w_req0 && w_req1) ? !w_owner_q : w_req1;
`endif

    assign w_addr_hs    = s_awready && s_wready;
    assign r_own_rready = r_owner_q ? m1_rready : m0_rready;
    assign w_own_bready = w_owner_q ? m1_bready : m0_bready;

    // Read channel next state: arbitrate, wait address handshake, wait response handshake.
    always_comb begin
        r_state_d = r_state_q;
        r_owner_d = r_owner_q;
        case (r_state_q)
            IDLE: if (m0_arvalid || m1_arvalid) begin
                r_owner_d = r_pick;
                r_state_d = ADDR;
            end
            ADDR: if (s_arready) r_state_d = RESP;
            RESP: if (s_rvalid && r_own_rready) r_state_d = IDLE;
            default: r_state_d = IDLE;
        endcase
    end

    // Write channel next state: same shape, AW and W accepted together.
    always_comb begin
        w_state_d = w_state_q;
        w_owner_d = w_owner_q;
        case (w_state_q)
            IDLE: if (w_req0 || w_req1) begin
                w_owner_d = w_pick;
                w_state_d = ADDR;
            end
            ADDR: if (w_addr_hs) w_state_d = RESP;
            RESP: if (s_bvalid && w_own_bready) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Read channel routing: owner-only forwarding, everything else held at 0.
    always_comb begin
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        case (r_state_q)
            ADDR: begin
                s_arvalid  = 1'b1;
                s_araddr   = r_owner_q ? m1_araddr : m0_araddr;
                m0_arready = !r_owner_q && s_arready;
                m1_arready =  r_owner_q && s_arready;
            end
            RESP: begin
                s_rready  = r_own_rready;
                m0_rvalid = !r_owner_q && s_rvalid;
                m1_rvalid =  r_owner_q && s_rvalid;
                m0_rdata  = r_owner_q ? '0 : s_rdata;
                m1_rdata  = r_owner_q ? s_rdata : '0;
            end
            default: ;
        endcase
    end

    // Write channel routing: owner-only forwarding, everything else held at 0.
    always_comb begin
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_awaddr   = '0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_bready   = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m1_bvalid  = 1'b0;
        case (w_state_q)
            ADDR: begin
                s_awvalid  = 1'b1;
                s_wvalid   = 1'b1;
                s_awaddr   = w_owner_q ? m1_awaddr : m0_awaddr;
                s_wdata    = w_owner_q ? m1_wdata  : m0_wdata;
                s_wstrb    = w_owner_q ? m1_wstrb  : m0_wstrb;
                m0_awready = !w_owner_q && w_addr_hs;
                m0_wready  = !w_owner_q && w_addr_hs;
                m1_awready =  w_owner_q && w_addr_hs;
                m1_wready  =  w_owner_q && w_addr_hs;
            end
            RESP: begin
                s_bready  = w_own_bready;
                m0_bvalid = !w_owner_q && s_bvalid;
                m1_bvalid =  w_owner_q && s_bvalid;
            end
            default: ;
        endcase
    end

    // State and owner registers; reset makes M1 the last-granted master.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= IDLE;
            w_state_q <= IDLE;
            r_owner_q <= 1'b1;
            w_owner_q <= 1'b1;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            r_owner_q <= r_owner_d;
            w_owner_q <= w_owner_d;
        end
    end

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
module tb_ram_port_b_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m0_awaddr = '0, m0_wdata = '0, m0_araddr = '0;
    logic [3:0]  m0_wstrb = '0;
    logic m0_awvalid = 0, m0_wvalid = 0, m0_bready = 0, m0_arvalid = 0, m0_rready = 0;
    logic [31:0] m1_awaddr = '0, m1_wdata = '0, m1_araddr = '0;
    logic [3:0]  m1_wstrb = '0;
    logic m1_awvalid = 0, m1_wvalid = 0, m1_bready = 0, m1_arvalid = 0, m1_rready = 0;
    logic m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid;
    logic m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic s_awready = 1'b1, s_wready = 1'b1, s_arready = 1'b1;
    logic s_bvalid, s_rvalid;

    ram_port_b_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_awaddr(m0_awaddr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_awvalid(m0_awvalid), .m0_wvalid(m0_wvalid), .m0_bready(m0_bready),
        .m0_arvalid(m0_arvalid), .m0_rready(m0_rready), .m0_araddr(m0_araddr),
        .m0_awready(m0_awready), .m0_wready(m0_wready), .m0_bvalid(m0_bvalid),
        .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_awaddr(m1_awaddr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_awvalid(m1_awvalid), .m1_wvalid(m1_wvalid), .m1_bready(m1_bready),
        .m1_arvalid(m1_arvalid), .m1_rready(m1_rready), .m1_araddr(m1_araddr),
        .m1_awready(m1_awready), .m1_wready(m1_wready), .m1_bvalid(m1_bvalid),
        .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_araddr(s_araddr),
        .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_rready(s_rready),
        .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    wire [178:0] all_outs = {m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid, m0_rdata,
                             m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid, m1_rdata,
                             s_awaddr, s_wdata, s_wstrb, s_araddr,
                             s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};
    wire [36:0] m1_outs = {m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid, m1_rdata};

    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;
    logic        ram_rvalid, ram_bvalid;
    logic [31:0] ram_rdata;
    assign s_rvalid = ram_rvalid;
    assign s_bvalid = ram_bvalid;
    assign s_rdata  = ram_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_rvalid <= 1'b0;
            ram_bvalid <= 1'b0;
            ram_rdata  <= '0;
        end else begin
            if (pre_en) mem[pre_idx] <= pre_data;
            if (s_arvalid) begin
                ram_rvalid <= 1'b1;
                ram_rdata  <= mem[s_araddr[7:2]];
            end else if (s_rready && ram_rvalid) begin
                ram_rvalid <= 1'b0;
            end
            if (s_awvalid && s_wvalid) begin
                ram_bvalid <= 1'b1;
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) mem[s_awaddr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end else if (s_bready && ram_bvalid) begin
                ram_bvalid <= 1'b0;
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    int          pidx [6] = '{0, 1, 2, 3, 4, 16};
    logic [31:0] pdat [6] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hCAFEF00D,
                              32'h0C0C0C0C, 32'h10101010, 32'hDEADBEEF};

    task automatic note(input string tag, input logic [63:0] obs, input logic [63:0] exp, input bit ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #3;
    endtask

    function automatic logic [31:0] pop_exp(input int m);
        if (m == 0) return (q0.size() > 0) ? q0.pop_front() : 32'hxxxxxxxx;
        return (q1.size() > 0) ? q1.pop_front() : 32'hxxxxxxxx;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic read_one(input int m, input logic [31:0] addr, input logic [31:0] exp);
        int  lat;
        bit  hs = 0;
        logic [31:0] got;
        logic [31:0] e;
        cyc();
        if (m == 0) begin m0_arvalid = 1; m0_araddr = addr; m0_rready = 1; q0.push_back(exp); end
        else        begin m1_arvalid = 1; m1_araddr = addr; m1_rready = 1; q1.push_back(exp); end
        settle();
        for (lat = 1; lat <= 20; lat++) begin
            cyc();
            if (hs) begin m0_arvalid = (m == 0) ? 1'b0 : m0_arvalid; m1_arvalid = (m == 1) ? 1'b0 : m1_arvalid; end
            settle();
            if ((m == 0) ? m0_rvalid : m1_rvalid) break;
            if ((m == 0) ? m0_arready : m1_arready) hs = 1;
        end
        note("read_latency", lat, 2, lat === 2);
        got = (m == 0) ? m0_rdata : m1_rdata;
        e = pop_exp(m);
        note("read_data", got, e, got === e);
        $display("read  m%0d addr %h data %h latency %0d", m, addr, got, lat);
        m0_arvalid = (m == 0) ? 1'b0 : m0_arvalid;
        m1_arvalid = (m == 1) ? 1'b0 : m1_arvalid;
    endtask

    task automatic tie_read(input int first);
        logic [31:0] got;
        logic [31:0] e;
        logic [1:0]  g;
        logic [1:0]  ge;
        cyc();
        m0_arvalid = 1; m0_araddr = 32'h00; m0_rready = 1;
        m1_arvalid = 1; m1_araddr = 32'h04; m1_rready = 1;
        q0.push_back(32'hA0A0A0A0);
        q1.push_back(32'hB1B1B1B1);
        settle();
        for (int k = 0; k < 2; k++) begin
            int who = (k == 0) ? first : 1 - first;
            ge = (who == 1) ? 2'b10 : 2'b01;
            cyc(); settle();
            g = {m1_arready, m0_arready};
            note("tie_grant", g, ge, g === ge);
            cyc();
            if (who == 0) m0_arvalid = 0; else m1_arvalid = 0;
            settle();
            got = (who == 0) ? m0_rdata : m1_rdata;
            g = {m1_rvalid, m0_rvalid};
            note("tie_rvalid", g, ge, g === ge);
            e = pop_exp(who);
            note("tie_rdata", got, e, got === e);
            $display("tie   slot %0d served m%0d data %h", k, who, got);
            cyc(); settle();
        end
    endtask

    initial begin
        logic [31:0] e;
        #1 rst_n = 1'b0;
        #2;
        note("reset_outputs", |all_outs, 1'b0, (|all_outs) === 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            pre_en = 1; pre_idx = 6'(pidx[i]); pre_data = pdat[i];
        end
        cyc(); pre_en = 0;

        cyc();
        m0_arvalid = 1; m0_araddr = 32'h40; m0_rready = 1;
        q0.push_back(32'hDEADBEEF);
        settle();
        note("single_no_comb_valid", s_arvalid, 1'b0, s_arvalid === 1'b0);
        cyc(); settle();
        note("single_s_arvalid", s_arvalid, 1'b1, s_arvalid === 1'b1);
        note("single_s_araddr", s_araddr, 32'h40, s_araddr === 32'h40);
        note("single_arready", m0_arready, 1'b1, m0_arready === 1'b1);
        cyc(); m0_arvalid = 0; settle();
        note("single_rvalid", m0_rvalid, 1'b1, m0_rvalid === 1'b1);
        e = pop_exp(0);
        note("single_rdata", m0_rdata, e, m0_rdata === e);
        note("single_m1_quiet", |m1_outs, 1'b0, (|m1_outs) === 1'b0);
        $display("read  m0 addr 00000040 data %h", m0_rdata);
        cyc(); settle();
        note("single_idle", m0_rvalid | s_arvalid, 1'b0, (m0_rvalid | s_arvalid) === 1'b0);

        do_reset();
        tie_read(0);
        read_one(0, 32'h10, 32'h10101010);
`ifdef RAM_ARB_FIXED_PRIO_EN
        tie_read(0);
`else
        tie_read(1);
`endif

        cyc();
        m0_awvalid = 1; m0_wvalid = 1; m0_awaddr = 32'h08; m0_wdata = 32'h11223344;
        m0_wstrb = 4'b0011; m0_bready = 1;
        m1_arvalid = 1; m1_araddr = 32'h0C; m1_rready = 1;
        q1.push_back(32'h0C0C0C0C);
        settle();
        cyc(); settle();
        note("conc_both_addr", {m0_awready, m0_wready, m1_arready}, 3'b111,
             {m0_awready, m0_wready, m1_arready} === 3'b111);
        note("conc_s_wstrb", s_wstrb, 4'b0011, s_wstrb === 4'b0011);
        note("conc_s_wdata", s_wdata, 32'h11223344, s_wdata === 32'h11223344);
        cyc(); m0_awvalid = 0; m0_wvalid = 0; m1_arvalid = 0; settle();
        note("conc_resp", {m0_bvalid, m1_rvalid}, 2'b11, {m0_bvalid, m1_rvalid} === 2'b11);
        e = pop_exp(1);
        note("conc_rdata", m1_rdata, e, m1_rdata === e);
        $display("conc  m0 write 08 bvalid %b, m1 read 0c data %h", m0_bvalid, m1_rdata);
        cyc(); settle();
        read_one(0, 32'h08, 32'hCAFE3344);

        cyc();
        m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h14; m1_wdata = 32'h5A5A1234;
        m1_wstrb = 4'hF; m1_bready = 0;
        settle();
        cyc(); settle();
        note("bp_m1_grant", m1_awready, 1'b1, m1_awready === 1'b1);
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (c == 0) begin
                m1_awvalid = 0; m1_wvalid = 0;
                m0_awvalid = 1; m0_wvalid = 1; m0_awaddr = 32'h18; m0_wdata = 32'h87654321;
                m0_wstrb = 4'hF; m0_bready = 1;
            end
            m1_bready = (c == 5);
            settle();
            note("bp_m1_bvalid_held", m1_bvalid, 1'b1, m1_bvalid === 1'b1);
            note("bp_m0_stalled", m0_awready, 1'b0, m0_awready === 1'b0);
            $display("bp    cycle %0d m1_bvalid %b m1_bready %b m0_awready %b", c, m1_bvalid, m1_bready, m0_awready);
        end
        cyc(); m1_bready = 0; settle();
        note("bp_idle_gap", m0_awready, 1'b0, m0_awready === 1'b0);
        cyc(); settle();
        note("bp_m0_grant", {m0_awready, s_awaddr}, {1'b1, 32'h18},
             {m0_awready, s_awaddr} === {1'b1, 32'h18});
        cyc(); m0_awvalid = 0; m0_wvalid = 0; settle();
        note("bp_m0_bvalid", m0_bvalid, 1'b1, m0_bvalid === 1'b1);
        cyc(); settle();
        read_one(1, 32'h14, 32'h5A5A1234);

        cyc();
        m1_awvalid = 1; m1_wvalid = 0; m1_awaddr = 32'h1C; m1_wdata = 32'h0BADCAFE;
        m1_wstrb = 4'hF; m1_bready = 1;
        settle();
        for (int c = 0; c < 3; c++) begin
            note("aw_only_no_grant", {s_awvalid, m1_awready}, 2'b00, {s_awvalid, m1_awready} === 2'b00);
            cyc(); settle();
        end
        m1_wvalid = 1;
        #1;
        note("aw_w_no_comb_valid", s_awvalid, 1'b0, s_awvalid === 1'b0);
        cyc(); settle();
        note("aw_w_grant", {s_awvalid, m1_awready, m1_wready}, 3'b111,
             {s_awvalid, m1_awready, m1_wready} === 3'b111);
        cyc(); m1_awvalid = 0; m1_wvalid = 0; settle();
        note("aw_w_bvalid", m1_bvalid, 1'b1, m1_bvalid === 1'b1);
        $display("awonly m1 write 1c granted after wvalid, bvalid %b", m1_bvalid);
        cyc(); settle();

        cyc();
        m0_arvalid = 1; m0_araddr = 32'h00; m0_rready = 0;
        settle();
        cyc(); settle();
        cyc(); m0_arvalid = 0; settle();
        cyc(); settle();
        note("rst_mid_in_resp", m0_rvalid, 1'b1, m0_rvalid === 1'b1);
        rst_n = 1'b0;
        #1;
        note("rst_mid_outputs", |all_outs, 1'b0, (|all_outs) === 1'b0);
        $display("reset mid-transaction, outputs cleared %b", ~|all_outs);
        cyc(); cyc();
        rst_n = 1'b1;
        read_one(0, 32'h10, 32'h10101010);

        note("scoreboard_drained", q0.size() + q1.size(), 0, (q0.size() + q1.size()) === 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule
